pic_8259: RTL and testbench
===========================

Name: pic_8259

Overview:
- Simplified 8259A-compatible programmable interrupt controller on the 12-bit I/O port bus.
- Sits directly downstream of the system timer. It consumes the timer's irq0 square wave on ir[0] and the other peripheral interrupt lines on ir[7:1].
- Drives the CPU interrupt request, supplies the interrupt vector on acknowledge, and exposes ICW/OCW programming at BASE/BASE+1.
- Supports edge-triggered, fixed-priority, single-controller operation only: IR0 is highest priority, IR7 is lowest.

Parameters:
- BASE, 12'h020, I/O address of the command/status port. The mask port is BASE+1.
- RESET_VECTOR, 8'h08, vector base loaded on reset. Only bits [7:3] are used.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- port  in  12  I/O address.
- iodin  in  8  I/O write data.
- iodout  out  8  I/O read data, registered.
- iord  in  1  I/O read strobe, 1 cycle per access.
- iowr  in  1  I/O write strobe, 1 cycle per access.
- ir  in  8  interrupt request lines. ir[0] = timer irq0.
- inta  in  1  CPU interrupt-acknowledge strobe, 1 cycle.
- intr  out  1  interrupt request to CPU, registered.
- vector  out  8  interrupt vector, registered, valid the cycle after inta.

Behaviour:
- Clock and reset: single clock domain, clk. Synchronous active-high reset.
- Reset values:
  - iodout=FF, intr=0, vector=00.
  - IRR=00, ISR=00, IMR=FF (all lines masked).
  - ir_prev=00, vbase=RESET_VECTOR[7:3], aeoi=0, rd_isr=0.
  - state=READY.
- Port decode: cs_cmd (port==BASE) and cs_mask (port==BASE+1) are registered one cycle. port must be stable at least 1 cycle before iord/iowr. Strobes qualify with the registered chip selects.
- Reads: iodout is registered and valid the cycle after iord.
  - cs_cmd: ISR if rd_isr=1, else IRR.
  - cs_mask: IMR.
  - Any other address: FF.
- Edge detect: ir_prev<=ir every cycle. A rising edge on ir[n] (ir[n]&~ir_prev[n]) sets IRR[n].
  - IRR[n] clears only on acknowledge of n, or on ICW1.
  - If a rising edge and the acknowledge of the same n occur in the same cycle, the set wins.
- Init FSM, states READY, ICW2, ICW3, ICW4:
  - Write cs_cmd with iodin[4]=1 is ICW1, from any state:
    - IRR=00, ISR=00, IMR=00, rd_isr=0, aeoi=0.
    - Store sngl=iodin[1], ic4=iodin[0].
    - Go to ICW2.
  - ICW2, write cs_mask: vbase=iodin[7:3]. Go to ICW3 if sngl=0, else ICW4 if ic4=1, else READY.
  - ICW3, write cs_mask: data ignored. Go to ICW4 if ic4=1, else READY.
  - ICW4, write cs_mask: aeoi=iodin[1]. Go to READY.
  - While not in READY: intr is held 0 and inta is ignored. Writes to cs_cmd with iodin[4]=0 are ignored.
- OCW decode, in READY only:
  - Write cs_mask: IMR=iodin (OCW1).
  - Write cs_cmd with iodin[4:3]=00 (OCW2):
    - iodin[7:5]=001: non-specific EOI, clears the highest-priority set ISR bit. No effect if ISR=00.
    - iodin[7:5]=011: specific EOI, clears ISR[iodin[2:0]].
    - Any other iodin[7:5] value is ignored.
  - Write cs_cmd with iodin[4:3]=01 (OCW3): if iodin[1]=1, rd_isr=iodin[0]. Otherwise no change.
- Priority resolution:
  - req = IRR & ~IMR.
  - hp = lowest index set in req.
  - cur = lowest index set in ISR, or 8 if ISR=00.
  - pend = req!=0 && hp<cur.
  - intr <= pend && state==READY, registered, so it follows the IRR change by 1 cycle.
  - A lower-priority request stays pending while a higher ISR bit is set. It raises intr after the EOI.
- Acknowledge, inta in READY:
  - If pend: IRR[hp]=0, ISR[hp]=1 (skipped when aeoi=1), vector<= {vbase,hp}.
  - If no pend (spurious): vector<= {vbase,3'd7}. IRR and ISR unchanged.
  - intr re-evaluates from the updated registers on the following cycle.
- Simultaneous events:
  - An EOI write and inta in the same cycle are both applied. The EOI clear is applied to ISR before the ack set.
  - ICW1 and inta in the same cycle: ICW1 wins and the ack is dropped. vector is still loaded with the spurious value.
- Reset mid-init returns the block to READY with the reset values above. The ICW sequence must be restarted.

Test Plan:
- Reset -> iodout after read of 0x21 = FF. intr=0 and stays 0 while pulsing ir[0].
- ICW1=0x13, ICW2=0x08, ICW4=0x01, OCW1=0xFE; pulse ir[0] low-to-high -> intr=1 two cycles later. inta -> vector=0x08, ISR=01 (OCW3 0x0B, read 0x20 returns 01), intr=0.
- With ir[0] in service, rising edge on ir[3] with IMR=F6 -> intr stays 0. OCW2 0x20 -> ISR=00, then intr=1. inta -> vector=0x0B.
- Simultaneous rising edges on ir[1] and ir[5], IMR=00 -> first inta vector=0x09, EOI, second inta vector=0x0D.
- inta with no pending request -> vector=0x0F, ISR unchanged. ICW4=0x03 (AEOI) then an ir[2] edge and inta -> vector=0x0A, ISR stays 00.
- Specific EOI 0x63 clears only ISR[3] with ISR=09 -> ISR=01. Read of unmapped port 0x040 returns FF.

Source files
------------

// File: rtl/pic_8259.sv
// Simplified 8259A-style interrupt controller: edge-triggered, fixed priority
// (IR0 highest), single controller, ICW/OCW programming at BASE and BASE+1.
module pic_8259 #(
  parameter logic [11:0] BASE         = 12'h020,
  parameter logic [7:0]  RESET_VECTOR = 8'h08
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] port,
  input  logic [7:0]  iodin,
  output logic [7:0]  iodout,
  input  logic        iord,
  input  logic        iowr,
  input  logic [7:0]  ir,
  input  logic        inta,
  output logic        intr,
  output logic [7:0]  vector
);

  typedef enum logic [1:0] {READY, ICW2, ICW3, ICW4} state_t;

  state_t      state, state_next;
  logic        cs_cmd, cs_mask;
  logic [7:0]  irr, isr, imr, ir_prev;
  logic [4:0]  vbase;
  logic        aeoi, rd_isr, sngl, ic4;

  logic        wr_cmd, wr_mask, icw1;
  logic        ready, load_vbase, load_aeoi, ocw1, ocw2, ocw3, ack;
  logic [7:0]  req, irr_next, isr_next;
  logic [2:0]  hp;
  logic [3:0]  cur;
  logic        pend;

  // Chip selects are registered, so the address must settle a cycle before the strobe.
  always_ff @(posedge clk) begin
    cs_cmd  <= (port == BASE);
    cs_mask <= (port == BASE + 12'd1);
  end

  assign wr_cmd  = iowr & cs_cmd;
  assign wr_mask = iowr & cs_mask;
  assign icw1    = wr_cmd & iodin[4];

  // Lowest set index wins: scan downwards so the last hit is the winner.
  always_comb begin
    req = irr & ~imr;
    hp  = 3'd0;
    cur = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) hp = 3'(i);
      if (isr[i]) cur = 4'(i);
    end
    pend = (req != 8'h00) && ({1'b0, hp} < cur);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= READY;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (icw1) begin
      state_next = ICW2;
    end else if (wr_mask) begin
      case (state)
        ICW2:    state_next = !sngl ? ICW3 : (ic4 ? ICW4 : READY);
        ICW3:    state_next = ic4 ? ICW4 : READY;
        ICW4:    state_next = READY;
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    ready      = (state == READY);
    load_vbase = (state == ICW2) && wr_mask;
    load_aeoi  = (state == ICW4) && wr_mask;
    ocw1       = ready && wr_mask;
    ocw2       = ready && wr_cmd && (iodin[4:3] == 2'b00);
    ocw3       = ready && wr_cmd && (iodin[4:3] == 2'b01);
    ack        = ready && inta && pend;
  end

  // EOI clears land before the acknowledge sets; a new edge beats its own ack.
  always_comb begin
    isr_next = isr;
    if (ocw2 && iodin[7:5] == 3'b001 && cur != 4'd8) isr_next[cur[2:0]] = 1'b0;
    if (ocw2 && iodin[7:5] == 3'b011)                isr_next[iodin[2:0]] = 1'b0;
    if (ack && !aeoi)                                isr_next[hp] = 1'b1;
    irr_next = irr;
    if (ack) irr_next[hp] = 1'b0;
    irr_next = irr_next | (ir & ~ir_prev);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iodout  <= 8'hFF;
      intr    <= 1'b0;
      vector  <= 8'h00;
      irr     <= 8'h00;
      isr     <= 8'h00;
      imr     <= 8'hFF;
      ir_prev <= 8'h00;
      vbase   <= RESET_VECTOR[7:3];
      aeoi    <= 1'b0;
      rd_isr  <= 1'b0;
      sngl    <= 1'b0;
      ic4     <= 1'b0;
    end else begin
      ir_prev <= ir;
      intr    <= pend && ready;
      if (iord) begin
        if (cs_cmd)       iodout <= rd_isr ? isr : irr;
        else if (cs_mask) iodout <= imr;
        else              iodout <= 8'hFF;
      end
      if (ready && inta)
        vector <= (pend && !icw1) ? {vbase, hp} : {vbase, 3'd7};
      if (icw1) begin
        irr    <= 8'h00;
        isr    <= 8'h00;
        imr    <= 8'h00;
        rd_isr <= 1'b0;
        aeoi   <= 1'b0;
        sngl   <= iodin[1];
        ic4    <= iodin[0];
      end else begin
        irr <= irr_next;
        isr <= isr_next;
        if (ocw1)               imr    <= iodin;
        if (ocw3 && iodin[1])   rd_isr <= iodin[0];
        if (load_vbase)         vbase  <= iodin[7:3];
        if (load_aeoi)          aeoi   <= iodin[1];
      end
    end
  end

endmodule

// File: tb/tb_pic_8259.sv
// Directed walk through the controller's programming and acknowledge flow,
// followed by random traffic, all compared against a behavioural model.
module tb_pic_8259;

  logic        clk, reset, iord, iowr, inta, intr;
  logic [11:0] port;
  logic [7:0]  iodin, iodout, ir, vector;
  int          checks = 0;
  int          failures = 0;

  pic_8259 dut (
    .clk(clk), .reset(reset), .port(port), .iodin(iodin), .iodout(iodout),
    .iord(iord), .iowr(iowr), .ir(ir), .inta(inta), .intr(intr), .vector(vector)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state; m_phase is 0 when programmed, else the number of the ICW awaited.
  logic [7:0] m_irr, m_isr, m_imr, m_prev, m_vec, m_dout;
  logic [4:0] m_vbase;
  logic       m_aeoi, m_rdisr, m_sngl, m_ic4, m_intr, m_csc, m_csm;
  int         m_phase;

  task automatic modelStep();
    int hp, cur;
    logic pend, rdy, wrc, wrm, icw1;
    if (reset) begin
      m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'hFF; m_prev = 8'h00;
      m_vec = 8'h00; m_dout = 8'hFF; m_vbase = 5'd1; m_aeoi = 0; m_rdisr = 0;
      m_sngl = 0; m_ic4 = 0; m_intr = 0; m_phase = 0;
    end else begin
      hp = 8; cur = 8;
      for (int i = 7; i >= 0; i--) begin
        if (m_irr[i] && !m_imr[i]) hp = i;
        if (m_isr[i]) cur = i;
      end
      pend = hp < cur;
      rdy  = (m_phase == 0);
      wrc  = iowr && m_csc;
      wrm  = iowr && m_csm;
      icw1 = wrc && iodin[4];
      m_intr = pend && rdy;
      if (iord) m_dout = m_csc ? (m_rdisr ? m_isr : m_irr) : (m_csm ? m_imr : 8'hFF);
      if (inta && rdy) m_vec = (pend && !icw1) ? {m_vbase, 3'(hp)} : {m_vbase, 3'd7};
      if (icw1) begin
        m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'h00; m_rdisr = 0; m_aeoi = 0;
        m_sngl = iodin[1]; m_ic4 = iodin[0]; m_phase = 2;
      end else begin
        if (m_phase == 2 && wrm) begin
          m_vbase = iodin[7:3];
          m_phase = !m_sngl ? 3 : (m_ic4 ? 4 : 0);
        end else if (m_phase == 3 && wrm) begin
          m_phase = m_ic4 ? 4 : 0;
        end else if (m_phase == 4 && wrm) begin
          m_aeoi = iodin[1];
          m_phase = 0;
        end else if (rdy) begin
          if (wrm) m_imr = iodin;
          if (wrc && iodin[4:3] == 2'b00) begin
            if (iodin[7:5] == 3'b001 && cur < 8) m_isr[cur] = 1'b0;
            if (iodin[7:5] == 3'b011) m_isr[iodin[2:0]] = 1'b0;
          end
          if (wrc && iodin[4:3] == 2'b01 && iodin[1]) m_rdisr = iodin[0];
          if (inta && pend) begin
            m_irr[hp] = 1'b0;
            if (!m_aeoi) m_isr[hp] = 1'b1;
          end
        end
        m_irr = m_irr | (ir & ~m_prev);
      end
    end
    m_prev = reset ? 8'h00 : ir;
    m_csc  = (port == 12'h020);
    m_csm  = (port == 12'h021);
  endtask

  task automatic checkValue(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%02h expected=%02h", tag, got, exp);
    end
  endtask

  task automatic checkOutput();
    checkValue("model_intr", {7'd0, intr}, {7'd0, m_intr});
    checkValue("model_vector", vector, m_vec);
    checkValue("model_iodout", iodout, m_dout);
  endtask

  task automatic step();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic ioWrite(input logic [11:0] a, input logic [7:0] d);
    port = a; iowr = 0; step();
    iowr = 1; iodin = d; step();
    iowr = 0;
  endtask

  task automatic ioRead(input logic [11:0] a);
    port = a; iord = 0; step();
    iord = 1; step();
    iord = 0;
  endtask

  task automatic pulseInta();
    inta = 1; step(); inta = 0;
  endtask

  initial begin
    reset = 1; port = 12'h000; iodin = 8'h00; iord = 0; iowr = 0; ir = 8'h00; inta = 0;
    applyStimulus(2);
    reset = 0;
    step();
    checkValue("reset_intr", {7'd0, intr}, 8'h00);
    checkValue("reset_vector", vector, 8'h00);
    checkValue("reset_iodout", iodout, 8'hFF);

    ioRead(12'h021);
    checkValue("reset_imr", iodout, 8'hFF);
    ir = 8'h01; applyStimulus(3);
    checkValue("masked_intr", {7'd0, intr}, 8'h00);
    ir = 8'h00; step();

    // Single-controller init with ICW4, then unmask only IR0.
    ioWrite(12'h020, 8'h13); ioWrite(12'h021, 8'h08); ioWrite(12'h021, 8'h01);
    ioWrite(12'h021, 8'hFE);
    ir = 8'h01; step(); step();
    checkValue("ir0_intr", {7'd0, intr}, 8'h01);
    pulseInta();
    checkValue("ir0_vector", vector, 8'h08);
    step();
    checkValue("ir0_intr_drop", {7'd0, intr}, 8'h00);
    ioWrite(12'h020, 8'h0B); ioRead(12'h020);
    checkValue("ir0_isr", iodout, 8'h01);

    // Lower-priority request waits for the EOI of IR0.
    ioWrite(12'h021, 8'hF6);
    ir = 8'h09; applyStimulus(3);
    checkValue("ir3_blocked", {7'd0, intr}, 8'h00);
    ioWrite(12'h020, 8'h20); step();
    checkValue("ir3_intr", {7'd0, intr}, 8'h01);
    pulseInta();
    checkValue("ir3_vector", vector, 8'h0B);
    ioRead(12'h020);
    checkValue("ir3_isr", iodout, 8'h08);

    // Two simultaneous edges resolve by priority.
    ioWrite(12'h020, 8'h20); ioWrite(12'h021, 8'h00);
    ir = 8'h00; step();
    ir = 8'h22; step(); step();
    pulseInta();
    checkValue("ir1_vector", vector, 8'h09);
    ioWrite(12'h020, 8'h20); step(); step();
    pulseInta();
    checkValue("ir5_vector", vector, 8'h0D);
    ioWrite(12'h020, 8'h20);

    // Spurious acknowledge.
    step(); step();
    pulseInta();
    checkValue("spurious_vector", vector, 8'h0F);
    ioRead(12'h020);
    checkValue("spurious_isr", iodout, 8'h00);

    // Automatic EOI leaves ISR empty.
    ioWrite(12'h020, 8'h13); ioWrite(12'h021, 8'h08); ioWrite(12'h021, 8'h03);
    ir = 8'h00; step();
    ir = 8'h04; step(); step();
    pulseInta();
    checkValue("aeoi_vector", vector, 8'h0A);
    ioWrite(12'h020, 8'h0B); ioRead(12'h020);
    checkValue("aeoi_isr", iodout, 8'h00);

    // Build ISR=09 (IR3 first, then IR0 nests), then a specific EOI on IR3.
    ioWrite(12'h020, 8'h13); ioWrite(12'h021, 8'h08); ioWrite(12'h021, 8'h01);
    ir = 8'h00; step();
    ir = 8'h08; step(); step();
    pulseInta();
    checkValue("nest_ir3_vector", vector, 8'h0B);
    ir = 8'h09; step(); step();
    pulseInta();
    checkValue("nest_ir0_vector", vector, 8'h08);
    ioWrite(12'h020, 8'h0B); ioRead(12'h020);
    checkValue("nest_isr", iodout, 8'h09);
    ioWrite(12'h020, 8'h63); ioRead(12'h020);
    checkValue("seoi_isr", iodout, 8'h01);
    ioRead(12'h040);
    checkValue("unmapped_read", iodout, 8'hFF);

    // Random traffic with a reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 3))
        0: port = 12'h020;
        1: port = 12'h021;
        2: port = 12'h040;
        default: port = 12'($urandom);
      endcase
      iodin = 8'($urandom);
      iowr  = ($urandom_range(0, 15) == 0);
      iord  = ($urandom_range(0, 7) == 0);
      inta  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) ir = 8'($urandom);
      reset = (c >= 1500 && c < 1502);
      step();
    end
    reset = 0; iowr = 0; iord = 0; inta = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
